// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared SAP datapath types: register operation modes
//
// Purpose: operation-select encoding for universal_reg, shared with the
//          control sequencer that drives the mode lines.
// Contents:
//   mode_t          - 3-bit register operation select
//   MIN_REG_WIDTH   - smallest legal register width (shift/rotate need 2 bits)
//   mode_keeps_carry- true for modes that leave the carry flag untouched
package sap_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_INC  = 3'b010,
        MODE_DEC  = 3'b011,
        MODE_SHL  = 3'b100,
        MODE_SHR  = 3'b101,
        MODE_ROL  = 3'b110,
        MODE_ROR  = 3'b111
    } mode_t;

    localparam int MIN_REG_WIDTH = 2;

    // HOLD and LOAD do not produce a carry; the flag keeps its old value.
    function automatic logic mode_keeps_carry(input mode_t m);
        return (m == MODE_HOLD) || (m == MODE_LOAD);
    endfunction

endpackage

// File: rtl/universal_reg_next.sv
// rtl/universal_reg_next.sv - combinational next-state for universal_reg
//
// Purpose: computes the next register value and carry for every mode.
//          Purely combinational; the caller decides whether to commit.
// Ports:
//   q          in  WIDTH  current register contents
//   d          in  WIDTH  parallel load data
//   ser_in     in  1      serial input (SHL/SHR only)
//   mode       in  mode_t operation select
//   q_next     out WIDTH  value q takes if this mode executes
//   carry_next out 1      carry/borrow/shifted-out bit (0 for HOLD/LOAD)
module universal_reg_next
    import sap_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  mode_t            mode,
    output logic [WIDTH-1:0] q_next,
    output logic             carry_next
);

    // One extra bit on each side of the add/subtract captures carry-out
    // and borrow directly, instead of detecting the wrap by comparison.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
    assign diff = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        q_next     = q;
        carry_next = 1'b0;
        case (mode)
            MODE_HOLD: begin
                q_next = q;
            end
            MODE_LOAD: begin
                q_next = d;
            end
            MODE_INC: begin
                q_next     = sum[WIDTH-1:0];
                carry_next = sum[WIDTH];
            end
            MODE_DEC: begin
                q_next     = diff[WIDTH-1:0];
                carry_next = diff[WIDTH];
            end
            MODE_SHL: begin
                q_next     = {q[WIDTH-2:0], ser_in};
                carry_next = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next     = {ser_in, q[WIDTH-1:1]};
                carry_next = q[0];
            end
            MODE_ROL: begin
                q_next     = {q[WIDTH-2:0], q[WIDTH-1]};
                carry_next = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next     = {q[0], q[WIDTH-1:1]};
                carry_next = q[0];
            end
            default: begin
                q_next     = q;
                carry_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_reg.sv
// rtl/universal_reg.sv - multi-mode SAP register with carry/zero flags and bus driver
//
// Purpose: WIDTH-bit register with load, inc/dec, shift and rotate, plus
//          registered carry and zero flags. Used for accumulator, B, PC and
//          output registers. Drives the OR-combined bus only when out_en.
// Ports:
//   clk      in  1      rising-edge clock
//   clear    in  1      asynchronous active-low reset
//   en       in  1      clock enable; low holds all state (also gates sync_clr)
//   sync_clr in  1      synchronous clear, overrides mode when en is high
//   mode     in  3      operation select (sap_pkg::mode_t encoding)
//   d        in  WIDTH  parallel load data
//   ser_in   in  1      serial input for SHL/SHR
//   out_en   in  1      bus output enable
//   q        out WIDTH  register contents
//   qbar     out WIDTH  ~q, combinational
//   bus_out  out WIDTH  q when out_en, else zero (never tri-stated)
//   carry    out 1      registered carry/borrow/shifted-out bit
//   zero     out 1      registered (q == 0)
module universal_reg
    import sap_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic             out_en,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] bus_out,
    output logic             carry,
    output logic             zero
);

    mode_t            mode_sel;
    logic [WIDTH-1:0] q_next;
    logic             carry_next;

    assign mode_sel = mode_t'(mode);

    universal_reg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q          (q),
        .d          (d),
        .ser_in     (ser_in),
        .mode       (mode_sel),
        .q_next     (q_next),
        .carry_next (carry_next)
    );

    // zero is derived from the value being written, so it lands in the
    // same edge as q and never depends combinationally on d.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q     <= RESET_VAL;
            carry <= 1'b0;
            zero  <= (RESET_VAL == '0);
        end else if (en) begin
            if (sync_clr) begin
                q     <= '0;
                carry <= 1'b0;
                zero  <= 1'b1;
            end else begin
                q    <= q_next;
                zero <= (q_next == '0);
                if (!mode_keeps_carry(mode_sel)) begin
                    carry <= carry_next;
                end
            end
        end
    end

    assign qbar    = ~q;
    assign bus_out = out_en ? q : '0;

endmodule
